// File: rtl/phvl_pkg.sv
// Shared types and constants for the phase-value serial loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phvl_pkg;

   localparam int NUM_EL     = 5;
   localparam int WORD_W     = 5;
   localparam int FRAME_BITS = NUM_EL * WORD_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH,
      ST_DONE
   } state_t;

   // Element 1 ends up in the top bits, so it is sent first, MSB first.
   // The shift register sends from its MSB, which holds phase1[4].
   function automatic logic [FRAME_BITS-1:0] pack_frame(
      input logic [WORD_W-1:0] p1,
      input logic [WORD_W-1:0] p2,
      input logic [WORD_W-1:0] p3,
      input logic [WORD_W-1:0] p4,
      input logic [WORD_W-1:0] p5
   );
      return {p1, p2, p3, p4, p5};
   endfunction

endpackage

// File: rtl/phvl_ser_tick.sv
// Half-period divider: pulses tick every HALF enabled cycles.
// Latency: first tick on the HALF-th enabled cycle.
// Backpressure: none; disabling clears the count so each enable starts fresh.
module phvl_ser_tick #(
   parameter int HALF = 2
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(HALF - 1));

   // Count enabled cycles, wrapping on each tick.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/phvl_loader.sv
// Serialises five phase words into one 25-bit frame with clock and latch strobe.
// Latency: load to done = 1 + 50*HALF + LE_W cycles.
// Backpressure: none; one-deep pending buffer, ovr pulses when it is overwritten.
module phvl_loader
   import phvl_pkg::*;
#(
   parameter int HALF = 2,
   parameter int LE_W = 2
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] phase1,
   input  logic [WORD_W-1:0] phase2,
   input  logic [WORD_W-1:0] phase3,
   input  logic [WORD_W-1:0] phase4,
   input  logic [WORD_W-1:0] phase5,
   output logic              ser_clk,
   output logic              ser_data,
   output logic              ser_le,
   output logic              busy,
   output logic              done,
   output logic              ovr
);

   localparam int LCW = $clog2(LE_W + 1);

   state_t                  state, nstate;
   logic [FRAME_BITS-1:0]   sr;
   logic [FRAME_BITS-1:0]   new_frame;
   logic [FRAME_BITS-1:0]   start_frame;
   logic [FRAME_BITS-1:0]   pend_frame;
   logic                    pend_flag;
   logic                    phase_hi;
   logic [4:0]              bit_cnt;
   logic [LCW-1:0]          le_cnt;
   logic                    start;
   logic                    tick;
   logic                    in_shift;

   assign new_frame = pack_frame(phase1, phase2, phase3, phase4, phase5);
   assign in_shift  = (state == ST_SHIFT);

   phvl_ser_tick #(.HALF(HALF)) u_tick (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en      (in_shift),
      .tick    (tick)
   );

   // State register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nstate;
   end

   // Next state; DONE restarts straight away from a same-cycle load or the pending frame.
   always_comb begin
      nstate      = state;
      start       = 1'b0;
      start_frame = new_frame;
      case (state)
         ST_IDLE: begin
            if (load) begin
               nstate = ST_SHIFT;
               start  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (tick && phase_hi && (bit_cnt == 5'(FRAME_BITS - 1)))
               nstate = ST_LATCH;
         end
         ST_LATCH: begin
            if (le_cnt == LCW'(LE_W - 1))
               nstate = ST_DONE;
         end
         ST_DONE: begin
            if (load || pend_flag) begin
               nstate      = ST_SHIFT;
               start       = 1'b1;
               start_frame = load ? new_frame : pend_frame;
            end else begin
               nstate = ST_IDLE;
            end
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // Shift datapath: low half then high half per bit, shift on the falling edge.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sr       <= '0;
         phase_hi <= 1'b0;
         bit_cnt  <= '0;
      end else if (start) begin
         sr       <= start_frame;
         phase_hi <= 1'b0;
         bit_cnt  <= '0;
      end else if (in_shift && tick) begin
         if (phase_hi) begin
            sr      <= {sr[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
         end
         phase_hi <= ~phase_hi;
      end
   end

   // Latch-enable width counter, only runs in LATCH.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst)
         le_cnt <= '0;
      else if (state == ST_LATCH)
         le_cnt <= le_cnt + 1'b1;
      else
         le_cnt <= '0;
   end

   // Pending buffer: loads during a frame park here; DONE always consumes the flag.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         pend_flag  <= 1'b0;
         pend_frame <= '0;
      end else if (state == ST_DONE) begin
         pend_flag <= 1'b0;
      end else if (load && (state != ST_IDLE)) begin
         pend_flag  <= 1'b1;
         pend_frame <= new_frame;
      end
   end

   assign ser_clk  = in_shift && phase_hi;
   assign ser_data = in_shift && sr[FRAME_BITS-1];
   assign ser_le   = (state == ST_LATCH);
   assign busy     = in_shift || (state == ST_LATCH);
   assign done     = (state == ST_DONE);
   assign ovr      = load && pend_flag;

endmodule

// File: tb/tb_phvl_loader.sv
module tb_phvl_loader;

   logic       sys_clk;
   logic       rst;
   logic       load_a, load_b;
   logic [4:0] p1, p2, p3, p4, p5;
   logic       ser_clk_a, ser_data_a, ser_le_a, busy_a, done_a, ovr_a;
   logic       ser_clk_b, ser_data_b, ser_le_b, busy_b, done_b, ovr_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [24:0] qa[$];
   logic [24:0] qb[$];

   // monitor state, DUT A (defaults)
   logic        pclk_a = 0, pdat_a = 0, pbusy_a = 0;
   logic [24:0] bits_a = 0;
   int rises_a = 0, first_rise_a = -1, le_first_a = -1, le_n_a = 0;
   int last_first_rise_a = -1, last_le_first_a = -1, last_le_n_a = 0;
   int done_n_a = 0, done_cyc_a = -1, ovr_n_a = 0, ovr_cyc_a = -1;
   int busy_rise_a = -1, stab_err_a = 0, le_total_a = 0, busy_cnt_a = 0;

   // monitor state, DUT B (HALF=1, LE_W=1)
   logic        pclk_b = 0, pdat_b = 0, pshift_b = 0;
   logic [24:0] bits_b = 0;
   int rises_b = 0, first_rise_b = -1, last_first_rise_b = -1;
   int done_n_b = 0, done_cyc_b = -1, alt_err_b = 0, stab_err_b = 0;

   phvl_loader #(.HALF(2), .LE_W(2)) dut_a (
      .sys_clk(sys_clk), .rst(rst), .load(load_a),
      .phase1(p1), .phase2(p2), .phase3(p3), .phase4(p4), .phase5(p5),
      .ser_clk(ser_clk_a), .ser_data(ser_data_a), .ser_le(ser_le_a),
      .busy(busy_a), .done(done_a), .ovr(ovr_a)
   );

   phvl_loader #(.HALF(1), .LE_W(1)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .load(load_b),
      .phase1(p1), .phase2(p2), .phase3(p3), .phase4(p4), .phase5(p5),
      .ser_clk(ser_clk_b), .ser_data(ser_data_b), .ser_le(ser_le_b),
      .busy(busy_b), .done(done_b), .ovr(ovr_b)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] frm(input logic [4:0] a, b, c, d, e);
      return {a, b, c, d, e};
   endfunction

   // Drive one load pulse starting now (#1 after a rising edge); returns #1 after the sampling edge.
   task automatic do_load(input bit to_a, input bit to_b, input logic [4:0] a, b, c, d, e);
      p1 = a; p2 = b; p3 = c; p4 = d; p5 = e;
      load_a = to_a;
      load_b = to_b;
      @(posedge sys_clk); #1;
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic wait_rel(input int n);
      while ((cyc - t0) < n) begin
         @(posedge sys_clk); #1;
      end
   endtask

   task automatic wait_done_a(input string tag, input int target, input int budget);
      int n = 0;
      while (done_n_a < target && n < budget) begin
         @(posedge sys_clk); #1;
         n++;
      end
      chk(tag, done_n_a, target);
   endtask

   // Scoreboard/monitor for A: collect bits on each ser_clk rise, compare on done.
   always @(negedge sys_clk) begin
      if (rst) begin
         rises_a = 0; bits_a = 0; first_rise_a = -1; le_first_a = -1; le_n_a = 0;
         pclk_a = 0; pdat_a = 0; pbusy_a = 0;
      end else begin
         if (busy_a) busy_cnt_a++;
         if (ser_clk_a && !pclk_a) begin
            rises_a++;
            bits_a = {bits_a[23:0], ser_data_a};
            if (first_rise_a < 0) first_rise_a = cyc;
         end
         if (ser_clk_a && pclk_a && (ser_data_a !== pdat_a)) stab_err_a++;
         if (ser_le_a) begin
            if (le_first_a < 0) le_first_a = cyc;
            le_n_a++;
            le_total_a++;
         end
         if (ovr_a) begin
            ovr_n_a++;
            ovr_cyc_a = cyc;
         end
         if (busy_a && !pbusy_a) busy_rise_a = cyc;
         if (done_a) begin
            done_n_a++;
            done_cyc_a = cyc;
            chk("a_busy_at_done", busy_a, 0);
            chk("a_queue_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) chk("a_frame_bits", bits_a, qa.pop_front());
            chk("a_rise_count", rises_a, 25);
            last_first_rise_a = first_rise_a;
            last_le_first_a   = le_first_a;
            last_le_n_a       = le_n_a;
            rises_a = 0; bits_a = 0; first_rise_a = -1; le_first_a = -1; le_n_a = 0;
         end
         pclk_a  = ser_clk_a;
         pdat_a  = ser_data_a;
         pbusy_a = busy_a;
      end
   end

   // Monitor for B: alternation and data stability at HALF=1.
   always @(negedge sys_clk) begin
      if (rst) begin
         rises_b = 0; bits_b = 0; first_rise_b = -1; pclk_b = 0; pdat_b = 0; pshift_b = 0;
      end else begin
         if (busy_b && !ser_le_b && pshift_b && (ser_clk_b === pclk_b)) alt_err_b++;
         if (ser_clk_b && !pclk_b) begin
            rises_b++;
            bits_b = {bits_b[23:0], ser_data_b};
            if (first_rise_b < 0) first_rise_b = cyc;
            if (ser_data_b !== pdat_b) stab_err_b++;
         end
         if (done_b) begin
            done_n_b++;
            done_cyc_b = cyc;
            chk("b_queue_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) chk("b_frame_bits", bits_b, qb.pop_front());
            chk("b_rise_count", rises_b, 25);
            last_first_rise_b = first_rise_b;
            rises_b = 0; bits_b = 0; first_rise_b = -1;
         end
         pclk_b   = ser_clk_b;
         pdat_b   = ser_data_b;
         pshift_b = busy_b && !ser_le_b;
      end
   end

   initial begin
      logic [24:0] fa, fb, fc;
      int n;
      rst = 1'b1; load_a = 1'b0; load_b = 1'b0;
      p1 = 0; p2 = 0; p3 = 0; p4 = 0; p5 = 0;
      fa = frm(5'h03, 5'h1C, 5'h12, 5'h07, 5'h18);
      fb = frm(5'h1E, 5'h01, 5'h0F, 5'h10, 5'h05);
      fc = frm(5'h09, 5'h16, 5'h0C, 5'h1B, 5'h02);

      // reset state
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_ser_clk", ser_clk_a, 0);
      chk("rst_ser_data", ser_data_a, 0);
      chk("rst_ser_le", ser_le_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_ovr", ovr_a, 0);
      rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("idle_busy", busy_a, 0);

      // basic frame on both instances
      qa.push_back(25'b10101_01010_11111_00000_10001);
      qb.push_back(25'b10101_01010_11111_00000_10001);
      do_load(1, 1, 5'h15, 5'h0A, 5'h1F, 5'h00, 5'h11);
      t0 = cyc - 1;
      @(negedge sys_clk);
      chk("c1_busy", busy_a, 1);
      chk("c1_ser_data", ser_data_a, 1);
      wait_done_a("t2_done_timeout", 1, 200);
      chk("t2_done_cycle", done_cyc_a - t0, 103);
      chk("t2_first_rise", last_first_rise_a - t0, 3);
      chk("t2_le_first", last_le_first_a - t0, 101);
      chk("t2_le_width", last_le_n_a, 2);
      chk("t2_stability", stab_err_a, 0);
      chk("b_done_count", done_n_b, 1);
      chk("b_done_cycle", done_cyc_b - t0, 52);
      chk("b_first_rise", last_first_rise_b - t0, 2);
      chk("b_alternation", alt_err_b, 0);
      chk("b_stability", stab_err_b, 0);
      repeat (5) @(posedge sys_clk);
      #1;

      // A then B at cycle 40: B restarts at done+1, no ovr
      ovr_n_a = 0;
      qa.push_back(fa);
      do_load(1, 0, 5'h03, 5'h1C, 5'h12, 5'h07, 5'h18);
      t0 = cyc - 1;
      wait_rel(40);
      qa.push_back(fb);
      do_load(1, 0, 5'h1E, 5'h01, 5'h0F, 5'h10, 5'h05);
      wait_done_a("t4_done1_timeout", 2, 200);
      chk("t4_done1_cycle", done_cyc_a - t0, 103);
      wait_done_a("t4_done2_timeout", 3, 200);
      chk("t4_busy_restart", busy_rise_a - t0, 104);
      chk("t4_done2_cycle", done_cyc_a - t0, 206);
      chk("t4_no_ovr", ovr_n_a, 0);
      repeat (5) @(posedge sys_clk);
      #1;

      // A, B at 20, C at 30: C overwrites B
      qa.push_back(fa);
      do_load(1, 0, 5'h03, 5'h1C, 5'h12, 5'h07, 5'h18);
      t0 = cyc - 1;
      wait_rel(20);
      qa.push_back(fb);
      do_load(1, 0, 5'h1E, 5'h01, 5'h0F, 5'h10, 5'h05);
      wait_rel(30);
      void'(qa.pop_back());
      qa.push_back(fc);
      do_load(1, 0, 5'h09, 5'h16, 5'h0C, 5'h1B, 5'h02);
      wait_done_a("t5_done2_timeout", 5, 400);
      chk("t5_ovr_count", ovr_n_a, 1);
      chk("t5_ovr_cycle", ovr_cyc_a - t0, 30);
      chk("t5_done2_cycle", done_cyc_a - t0, 206);
      repeat (5) @(posedge sys_clk);
      #1;

      // reset mid-frame with a pending load
      qa.push_back(fa);
      do_load(1, 0, 5'h03, 5'h1C, 5'h12, 5'h07, 5'h18);
      t0 = cyc - 1;
      wait_rel(10);
      do_load(1, 0, 5'h1E, 5'h01, 5'h0F, 5'h10, 5'h05);
      wait_rel(50);
      chk("t6_busy_before_rst", busy_a, 1);
      rst = 1'b1;
      #1;
      qa.delete();
      chk("t6_rst_ser_clk", ser_clk_a, 0);
      chk("t6_rst_ser_data", ser_data_a, 0);
      chk("t6_rst_ser_le", ser_le_a, 0);
      chk("t6_rst_busy", busy_a, 0);
      chk("t6_rst_done", done_a, 0);
      chk("t6_rst_ovr", ovr_a, 0);
      repeat (2) @(posedge sys_clk);
      #1;
      rst = 1'b0;
      n = done_n_a;
      le_total_a = 0;
      busy_cnt_a = 0;
      repeat (300) @(posedge sys_clk);
      #1;
      chk("t6_no_le", le_total_a, 0);
      chk("t6_no_restart", busy_cnt_a, 0);
      chk("t6_no_done", done_n_a - n, 0);

      // load coinciding with done
      ovr_n_a = 0;
      qa.push_back(fb);
      do_load(1, 0, 5'h1E, 5'h01, 5'h0F, 5'h10, 5'h05);
      t0 = cyc - 1;
      wait_rel(103);
      chk("t7_in_done", done_a, 1);
      qa.push_back(fc);
      do_load(1, 0, 5'h09, 5'h16, 5'h0C, 5'h1B, 5'h02);
      @(negedge sys_clk);
      chk("t7_busy_next", busy_a, 1);
      wait_done_a("t7_done2_timeout", n + 2, 250);
      chk("t7_done2_cycle", done_cyc_a - t0, 206);
      chk("t7_no_ovr", ovr_n_a, 0);
      repeat (5) @(posedge sys_clk);
      #1;
      chk("final_queue_a_empty", qa.size(), 0);
      chk("final_queue_b_empty", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
